// File: rtl/acc_pkg.sv
// Shared definitions for the 16-bit accumulator machine.
// Holds the opcode map, sequencer states, decode classes and address-width derivation.
package acc_pkg;

  function automatic int addr_bits(input int bits);
    return bits - 5;
  endfunction

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LDA_D = 5'b00010;
  localparam logic [4:0] OP_LDA_I = 5'b00011;
  localparam logic [4:0] OP_ADD_D = 5'b00100;
  localparam logic [4:0] OP_ADD_I = 5'b00101;
  localparam logic [4:0] OP_SUB_D = 5'b00110;
  localparam logic [4:0] OP_SUB_I = 5'b00111;
  localparam logic [4:0] OP_STA   = 5'b01000;
  localparam logic [4:0] OP_JMP   = 5'b01001;
  localparam logic [4:0] OP_JZ    = 5'b01010;
  localparam logic [4:0] OP_JN    = 5'b01011;
  localparam logic [4:0] OP_NOT   = 5'b01111;
  localparam logic [4:0] OP_AND_D = 5'b10000;
  localparam logic [4:0] OP_AND_I = 5'b10001;
  localparam logic [4:0] OP_OR_D  = 5'b10010;
  localparam logic [4:0] OP_OR_I  = 5'b10011;
  localparam logic [4:0] OP_XOR_D = 5'b10100;
  localparam logic [4:0] OP_XOR_I = 5'b10101;
  localparam logic [4:0] OP_SHL   = 5'b10110;
  localparam logic [4:0] OP_SHR   = 5'b10111;
  localparam logic [4:0] OP_LDX   = 5'b11001;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_OPERAND, S_INDIRECT, S_EXEC, S_STORE, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    OPND_NONE, OPND_IMM, OPND_DIR, OPND_IND
  } opnd_class_t;

  typedef enum logic [2:0] {
    CTL_NOP, CTL_ALU, CTL_STA, CTL_JMP, CTL_JZ, CTL_JN, CTL_HALT
  } ctl_class_t;

endpackage

// File: rtl/acc_decode.sv
// Opcode classifier: how the operand is obtained and what kind of control action follows.
module acc_decode
  import acc_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [1:0] opnd_class,
  output logic [2:0] ctl_class
);

  always_comb begin
    opnd_class = OPND_NONE;
    ctl_class  = CTL_NOP;
    case (opcode)
      OP_LDA_D, OP_ADD_D, OP_SUB_D, OP_AND_D, OP_OR_D, OP_XOR_D: begin
        opnd_class = OPND_DIR;
        ctl_class  = CTL_ALU;
      end
      OP_LDA_I, OP_ADD_I, OP_SUB_I, OP_AND_I, OP_OR_I, OP_XOR_I, OP_SHL, OP_SHR: begin
        opnd_class = OPND_IMM;
        ctl_class  = CTL_ALU;
      end
      // NOT works on acc alone; the operand register is cleared for it
      OP_NOT:  ctl_class = CTL_ALU;
      OP_LDX: begin
        opnd_class = OPND_IND;
        ctl_class  = CTL_ALU;
      end
      OP_STA:  ctl_class = CTL_STA;
      OP_JMP:  ctl_class = CTL_JMP;
      OP_JZ:   ctl_class = CTL_JZ;
      OP_JN:   ctl_class = CTL_JN;
      OP_HALT: ctl_class = CTL_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// Instruction sequencer and accumulator owner: fetch, decode, operand fetch,
// ALU write-back, stores and branches over a single shared memory port.
module acc_sequencer
  import acc_pkg::*;
#(
  parameter  int BITS      = 16,
  localparam int ADDR_BITS = addr_bits(BITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [BITS-1:0]      mem_wdata,
  input  logic                 mem_ack,
  input  logic [BITS-1:0]      mem_rdata,
  output logic [BITS-1:0]      alu_a,
  output logic [BITS-1:0]      alu_acc,
  output logic [4:0]           alu_opcode,
  input  logic [BITS-1:0]      alu_result,
  output logic [ADDR_BITS-1:0] pc,
  output logic [BITS-1:0]      acc,
  output logic                 halted
);

  state_t                state, state_nxt;
  logic [BITS-1:0]       ir;
  logic [BITS-1:0]       opnd;
  logic [ADDR_BITS-1:0]  f;
  logic [1:0]            opnd_class_raw;
  logic [2:0]            ctl_class_raw;
  opnd_class_t           oc;
  ctl_class_t            ctl;
  logic                  take_branch;
  logic                  needs_mem_opnd;

  assign f          = ir[ADDR_BITS-1:0];
  assign alu_opcode = ir[BITS-1:BITS-5];
  assign alu_a      = opnd;
  assign alu_acc    = acc;
  assign mem_wdata  = acc;

  acc_decode u_decode (
    .opcode     (ir[BITS-1:BITS-5]),
    .opnd_class (opnd_class_raw),
    .ctl_class  (ctl_class_raw)
  );

  assign oc  = opnd_class_t'(opnd_class_raw);
  assign ctl = ctl_class_t'(ctl_class_raw);

  assign needs_mem_opnd = (oc == OPND_DIR) || (oc == OPND_IND);
  assign take_branch    = (ctl == CTL_JMP)
                       || ((ctl == CTL_JZ) && (acc == '0))
                       || ((ctl == CTL_JN) && acc[BITS-1]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:     state_nxt = S_FETCH;
      S_FETCH:    if (mem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        case (ctl)
          CTL_ALU:  state_nxt = needs_mem_opnd ? S_OPERAND : S_EXEC;
          CTL_STA:  state_nxt = S_STORE;
          CTL_HALT: state_nxt = S_HALT;
          default:  state_nxt = S_FETCH;
        endcase
      end
      S_OPERAND:  if (mem_ack) state_nxt = (oc == OPND_IND) ? S_INDIRECT : S_EXEC;
      S_INDIRECT: if (mem_ack) state_nxt = S_EXEC;
      S_EXEC:     state_nxt = S_FETCH;
      S_STORE:    if (mem_ack) state_nxt = S_FETCH;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_BOOT;
    endcase
  end

  // Request is masked by rst so it drops in the very cycle reset is asserted
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    halted   = 1'b0;
    case (state)
      S_FETCH:    begin mem_req = 1'b1; mem_addr = pc; end
      S_OPERAND:  begin mem_req = 1'b1; mem_addr = f; end
      S_INDIRECT: begin mem_req = 1'b1; mem_addr = opnd[ADDR_BITS-1:0]; end
      S_STORE:    begin mem_req = 1'b1; mem_we = 1'b1; mem_addr = f; end
      S_HALT:     halted = 1'b1;
      default: ;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= '0;
      acc  <= '0;
      ir   <= '0;
      opnd <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + 1'b1;
          end
        end
        S_DECODE: begin
          if (take_branch) pc <= f;
          if (oc == OPND_IMM)
            opnd <= {{(BITS-ADDR_BITS){1'b0}}, f};
          else if ((oc == OPND_NONE) && (ctl == CTL_ALU))
            opnd <= '0;
        end
        S_OPERAND, S_INDIRECT: begin
          if (mem_ack) opnd <= mem_rdata;
        end
        S_EXEC:  acc <= alu_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: behavioural memory with programmable ack delay,
// a small ALU model, and a scoreboard of expected memory transactions.
module tb_acc_sequencer;
  import acc_pkg::*;

  localparam int BITS = 16;
  localparam int AW   = 11;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [BITS-1:0] data;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mem_req, mem_we, mem_ack;
  logic [AW-1:0]   mem_addr, pc;
  logic [BITS-1:0] mem_wdata, mem_rdata, alu_a, alu_acc, alu_result, acc;
  logic [4:0]      alu_opcode;
  logic            halted;

  logic [BITS-1:0] mem [0:2047];
  txn_t            sb_q[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  int              wait_cnt = 0;
  int              rd_delay = 0;
  int              wr_delay = 0;
  logic            hold_en = 1'b0;
  logic [AW-1:0]   hold_addr = '0;
  logic            late_ack = 1'b0;
  logic            sb_on = 1'b0;

  acc_sequencer #(.BITS(BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .alu_a      (alu_a),
    .alu_acc    (alu_acc),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .pc         (pc),
    .acc        (acc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] alu_model(input logic [4:0] op,
                                                input logic [BITS-1:0] a,
                                                input logic [BITS-1:0] av);
    case (op)
      5'b00010, 5'b00011, 5'b11001: return a;
      5'b00100, 5'b00101:           return av + a;
      5'b00110, 5'b00111:           return av - a;
      5'b01111:                     return ~av;
      5'b10000, 5'b10001:           return av & a;
      5'b10010, 5'b10011:           return av | a;
      5'b10100, 5'b10101:           return av ^ a;
      5'b10110:                     return av << a[3:0];
      5'b10111:                     return av >> a[3:0];
      default:                      return av;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_opcode, alu_a, alu_acc);

  always_comb begin
    mem_ack = late_ack;
    if (mem_req === 1'b1 && !(hold_en && mem_addr == hold_addr)
        && wait_cnt >= (mem_we ? wr_delay : rd_delay))
      mem_ack = 1'b1;
  end

  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    txn_t e;
    n_cmp++;
    assert (sb_q.size() != 0) else begin
      n_bad++;
      $error("FAIL sb_extra observed we=%b addr=%0d expected no transaction", mem_we, mem_addr);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      assert (mem_we === e.we && mem_addr === e.addr && (e.we === 1'b0 || mem_wdata === e.data))
      else begin
        n_bad++;
        $error("FAIL sb_txn observed we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
               mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
      end
    end
  endtask

  // One clock: completed transactions are scored just before the edge that retires them
  task automatic step();
    int wnext;
    #1;
    if (sb_on && mem_req === 1'b1 && mem_ack === 1'b1) sb_check();
    if (mem_req === 1'b1 && mem_we === 1'b1 && mem_ack === 1'b1) mem[mem_addr] = mem_wdata;
    wnext = (mem_req === 1'b1 && mem_ack !== 1'b1) ? wait_cnt + 1 : 0;
    @(posedge clk);
    #1;
    wait_cnt = wnext;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = '0;
  endtask

  task automatic push_rd(input logic [AW-1:0] a);
    sb_q.push_back({1'b0, a, 16'h0000});
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [BITS-1:0] d);
    sb_q.push_back({1'b1, a, d});
  endtask

  task automatic sb_begin();
    sb_q.delete();
    sb_on = 1'b1;
  endtask

  task automatic sb_end(input string tag);
    chk({tag, "_sb_drained"}, sb_q.size(), 0);
    sb_on = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  initial begin
    int k;

    // LDA #5, ADD #3, HALT with zero-wait memory
    clear_mem();
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0800;
    sb_begin(); push_rd(0); push_rd(1); push_rd(2);
    rst = 1'b1;
    steps(2);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_opnd", alu_a, 0);
    rst = 1'b0;
    step();
    chk("t1_fetch_req", mem_req, 1);
    chk("t1_fetch_addr", mem_addr, 0);
    steps(3);
    chk("t1_acc_lda", acc, 16'h0005);
    steps(4);
    chk("t1_halted_c7", halted, 0);
    step();
    chk("t1_halted_c8", halted, 1);
    chk("t1_acc_final", acc, 16'h0008);
    sb_end("t1");

    // Direct SUB going negative, then JN taken to 40
    clear_mem();
    mem[0] = 16'h3064; mem[100] = 16'h0007; mem[1] = 16'h5828; mem[40] = 16'h0800;
    sb_begin(); push_rd(0); push_rd(100); push_rd(1); push_rd(40);
    do_reset();
    step();
    steps(2);
    chk("t2_operand_addr", mem_addr, 100);
    chk("t2_operand_we", mem_we, 0);
    step();
    chk("t2_alu_a", alu_a, 16'h0007);
    chk("t2_alu_opcode", alu_opcode, 5'b00110);
    chk("t2_alu_acc", alu_acc, 16'h0000);
    step();
    chk("t2_acc_sub", acc, 16'hFFF9);
    steps(2);
    chk("t2_jn_pc", pc, 40);
    chk("t2_jn_fetch", {mem_req, mem_addr}, {1'b1, 11'd40});
    steps(2);
    chk("t2_halted", halted, 1);
    sb_end("t2");

    // LDX double indirection
    clear_mem();
    mem[0] = 16'hC80A; mem[10] = 16'h0014; mem[20] = 16'hBEEF; mem[1] = 16'h0800;
    sb_begin(); push_rd(0); push_rd(10); push_rd(20); push_rd(1);
    do_reset();
    step();
    steps(3);
    chk("t3_indirect_addr", mem_addr, 20);
    step();
    chk("t3_acc_exec", acc, 16'h0000);
    chk("t3_alu_a", alu_a, 16'hBEEF);
    step();
    chk("t3_acc_ldx", acc, 16'hBEEF);
    steps(2);
    chk("t3_halted", halted, 1);
    sb_end("t3");

    // STA with three wait cycles on the write
    clear_mem();
    mem[0] = 16'h103C; mem[60] = 16'h1234; mem[1] = 16'h4032; mem[2] = 16'h0800;
    wr_delay = 3;
    sb_begin(); push_rd(0); push_rd(60); push_rd(1); push_wr(50, 16'h1234); push_rd(2);
    do_reset();
    step();
    steps(4);
    chk("t4_acc_lda", acc, 16'h1234);
    steps(2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_req_w%0d", i), mem_req, 1);
      chk($sformatf("t4_we_w%0d", i), mem_we, 1);
      chk($sformatf("t4_addr_w%0d", i), mem_addr, 50);
      chk($sformatf("t4_wdata_w%0d", i), mem_wdata, 16'h1234);
      if (i < 3) step();
    end
    step();
    chk("t4_after_store", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 11'd2});
    chk("t4_mem50", mem[50], 16'h1234);
    steps(2);
    chk("t4_halted", halted, 1);
    sb_end("t4");
    wr_delay = 0;

    // Reset pulsed while an operand read is stalled
    clear_mem();
    mem[0] = 16'h1805; mem[1] = 16'h3064; mem[100] = 16'h0007;
    hold_en = 1'b1; hold_addr = 11'd100;
    sb_begin(); push_rd(0); push_rd(1);
    do_reset();
    step();
    k = 0;
    while (!(mem_req === 1'b1 && mem_addr == 11'd100) && k < 20) begin
      step();
      k++;
    end
    chk("t5_operand_reached", (mem_req === 1'b1 && mem_addr == 11'd100), 1);
    steps(2);
    chk("t5_wait_req", {mem_req, mem_addr}, {1'b1, 11'd100});
    chk("t5_wait_acc", acc, 16'h0005);
    chk("t5_wait_pc", pc, 2);
    sb_end("t5");
    rst = 1'b1; late_ack = 1'b1;
    #1;
    chk("t5_rst_req_drop", mem_req, 0);
    chk("t5_rst_we_drop", mem_we, 0);
    step();
    rst = 1'b0;
    #1;
    chk("t5_boot_req", mem_req, 0);
    chk("t5_boot_pc", pc, 0);
    chk("t5_boot_acc", acc, 0);
    chk("t5_boot_opnd", alu_a, 0);
    chk("t5_boot_halted", halted, 0);
    hold_en = 1'b0;
    step();
    late_ack = 1'b0;
    chk("t5_refetch", {mem_req, mem_addr}, {1'b1, 11'd0});
    chk("t5_refetch_opnd", alu_a, 0);

    // JZ taken to 2047, NOP there, pc wraps to 0
    clear_mem();
    mem[0] = 16'h57FF; mem[2047] = 16'h0000;
    sb_begin(); push_rd(0); push_rd(2047); push_rd(0);
    do_reset();
    step();
    steps(2);
    chk("t6_jz_taken_addr", mem_addr, 2047);
    chk("t6_jz_taken_pc", pc, 2047);
    step();
    chk("t6_wrap_pc", pc, 0);
    step();
    chk("t6_wrap_fetch", {mem_req, mem_addr}, {1'b1, 11'd0});
    step();
    sb_end("t6a");

    // JZ with acc = 1 falls through
    clear_mem();
    mem[0] = 16'h1801; mem[1] = 16'h5064; mem[2] = 16'h0800;
    sb_begin(); push_rd(0); push_rd(1); push_rd(2);
    do_reset();
    step();
    steps(3);
    chk("t6_acc_one", acc, 16'h0001);
    steps(2);
    chk("t6_jz_not_taken_addr", mem_addr, 2);
    chk("t6_jz_not_taken_pc", pc, 2);
    steps(2);
    chk("t6_halted", halted, 1);
    sb_end("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
